// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Carries the EX result, store data, destination index and memory controls
// into the MEM stage. It supports stall (hold), flush (bubble), squashing of
// misaligned accesses, and a sticky HALT drain mode that only reset can leave.
module ex_mem_reg #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_flush,
    input  logic [DATA_BUS_WIDTH-1:0] i_alu_result,
    input  logic [DATA_BUS_WIDTH-1:0] i_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic                      i_reg_write,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic                      i_mem_to_reg,
    input  logic                      i_mem_unsigned,
    input  logic [1:0]                i_mem_width,
    input  logic                      i_halt,
    output logic [DATA_BUS_WIDTH-1:0] o_alu_result,
    output logic [DATA_BUS_WIDTH-1:0] o_store_data,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic                      o_reg_write,
    output logic                      o_mem_read,
    output logic                      o_mem_write,
    output logic                      o_mem_to_reg,
    output logic                      o_mem_unsigned,
    output logic [1:0]                o_mem_width,
    output logic                      o_halt,
    output logic                      o_valid,
    output logic                      o_misaligned,
    output logic                      o_halted
);

    // Access size encoding on i_mem_width.
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;
    localparam logic [1:0] WIDTH_RSVD = 2'b11;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state;
    logic   misaligned;

    // Misalignment of the incoming access; only real memory ops can be misaligned.
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // misaligned unassigned, which would infer a latch.
        misaligned = 1'b0;
        if (i_mem_read || i_mem_write) begin
            case (i_mem_width)
                WIDTH_BYTE: misaligned = 1'b0;
                WIDTH_HALF: misaligned = i_alu_result[0];
                WIDTH_WORD: misaligned = |i_alu_result[1:0];
                WIDTH_RSVD: misaligned = 1'b1;
                default:    misaligned = 1'b0;
            endcase
        end
    end

    // Stage register and RUN/HALTED state; priority reset > flush > halted > stall > load.
    always_ff @(posedge i_clk or negedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!i_reset) begin
            state          <= RUN;
            o_alu_result   <= '0;
            o_store_data   <= '0;
            o_rd           <= '0;
            o_reg_write    <= 1'b0;
            o_mem_read     <= 1'b0;
            o_mem_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_mem_unsigned <= 1'b0;
            o_mem_width    <= '0;
            o_halt         <= 1'b0;
            o_valid        <= 1'b0;
            o_misaligned   <= 1'b0;
        end else if (i_flush || state == HALTED) begin
            // Bubble: a flush never changes state, so it neither enters nor
            // leaves HALTED; a HALT arriving with a flush is discarded here.
            o_alu_result   <= '0;
            o_store_data   <= '0;
            o_rd           <= '0;
            o_reg_write    <= 1'b0;
            o_mem_read     <= 1'b0;
            o_mem_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_mem_unsigned <= 1'b0;
            o_mem_width    <= '0;
            o_halt         <= 1'b0;
            o_valid        <= 1'b0;
            o_misaligned   <= 1'b0;
        end else if (i_enable) begin
            // Misaligned accesses are latched for visibility but squashed so
            // neither memory nor the register file is touched.
            o_alu_result   <= i_alu_result;
            o_store_data   <= i_store_data;
            o_rd           <= i_rd;
            o_reg_write    <= i_reg_write && !misaligned;
            o_mem_read     <= i_mem_read  && !misaligned;
            o_mem_write    <= i_mem_write && !misaligned;
            o_mem_to_reg   <= i_mem_to_reg;
            o_mem_unsigned <= i_mem_unsigned;
            o_mem_width    <= i_mem_width;
            o_halt         <= i_halt;
            o_valid        <= 1'b1;
            o_misaligned   <= misaligned;
            state          <= i_halt ? HALTED : RUN;
        end
        // Otherwise stalled: every register keeps its value.
    end

    // Sticky halt flag comes straight from the registered state.
    assign o_halted = (state == HALTED);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, table-driven bench for ex_mem_reg: one vector per clock edge,
// expected outputs written by hand, followed by asynchronous-reset sequences.
module tb_ex_mem_reg;

    typedef struct packed {
        logic        en;
        logic        fl;
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        mu;
        logic [1:0]  w;
        logic        h;
    } in_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        mu;
        logic [1:0]  w;
        logic        h;
        logic        valid;
        logic        mis;
        logic        halted;
    } out_t;

    typedef struct {
        string name;
        in_t   stim;
        out_t  exp;
    } vec_t;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic        i_flush;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_mem_to_reg;
    logic        i_mem_unsigned;
    logic [1:0]  i_mem_width;
    logic        i_halt;
    logic [31:0] o_alu_result;
    logic [31:0] o_store_data;
    logic [4:0]  o_rd;
    logic        o_reg_write;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_mem_to_reg;
    logic        o_mem_unsigned;
    logic [1:0]  o_mem_width;
    logic        o_halt;
    logic        o_valid;
    logic        o_misaligned;
    logic        o_halted;

    out_t act;
    int   total;
    int   bad;
    vec_t vecs[$];

    ex_mem_reg #(.DATA_BUS_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_flush        (i_flush),
        .i_alu_result   (i_alu_result),
        .i_store_data   (i_store_data),
        .i_rd           (i_rd),
        .i_reg_write    (i_reg_write),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_mem_to_reg   (i_mem_to_reg),
        .i_mem_unsigned (i_mem_unsigned),
        .i_mem_width    (i_mem_width),
        .i_halt         (i_halt),
        .o_alu_result   (o_alu_result),
        .o_store_data   (o_store_data),
        .o_rd           (o_rd),
        .o_reg_write    (o_reg_write),
        .o_mem_read     (o_mem_read),
        .o_mem_write    (o_mem_write),
        .o_mem_to_reg   (o_mem_to_reg),
        .o_mem_unsigned (o_mem_unsigned),
        .o_mem_width    (o_mem_width),
        .o_halt         (o_halt),
        .o_valid        (o_valid),
        .o_misaligned   (o_misaligned),
        .o_halted       (o_halted)
    );

    assign act = {o_alu_result, o_store_data, o_rd, o_reg_write, o_mem_read,
                  o_mem_write, o_mem_to_reg, o_mem_unsigned, o_mem_width,
                  o_halt, o_valid, o_misaligned, o_halted};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input out_t a, input out_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic drive(input in_t s);
        i_enable       = s.en;
        i_flush        = s.fl;
        i_alu_result   = s.alu;
        i_store_data   = s.st;
        i_rd           = s.rd;
        i_reg_write    = s.rw;
        i_mem_read     = s.mr;
        i_mem_write    = s.mw;
        i_mem_to_reg   = s.m2r;
        i_mem_unsigned = s.mu;
        i_mem_width    = s.w;
        i_halt         = s.h;
    endtask

    // Apply one vector, take one rising edge, sample 1 time unit later.
    task automatic step(input string name, input in_t s, input out_t e);
        drive(s);
        @(posedge i_clk);
        #1;
        check(name, act, e);
    endtask

    function automatic in_t mk_in(input logic en, input logic fl,
                                  input logic [31:0] alu, input logic [31:0] st,
                                  input logic [4:0] rd, input logic rw,
                                  input logic mr, input logic mw, input logic m2r,
                                  input logic mu, input logic [1:0] w,
                                  input logic h);
        in_t r;
        r = {en, fl, alu, st, rd, rw, mr, mw, m2r, mu, w, h};
        return r;
    endfunction

    function automatic out_t mk_out(input logic [31:0] alu, input logic [31:0] st,
                                    input logic [4:0] rd, input logic rw,
                                    input logic mr, input logic mw, input logic m2r,
                                    input logic mu, input logic [1:0] w,
                                    input logic h, input logic v, input logic mis,
                                    input logic hd);
        out_t r;
        r = {alu, st, rd, rw, mr, mw, m2r, mu, w, h, v, mis, hd};
        return r;
    endfunction

    function automatic vec_t mk_vec(input string n, input in_t s, input out_t e);
        vec_t r;
        r.name = n;
        r.stim = s;
        r.exp  = e;
        return r;
    endfunction

    initial begin
        out_t bubble;
        out_t bubble_h;
        out_t hold7;
        in_t  idle;
        total    = 0;
        bad      = 0;
        bubble   = '0;
        bubble_h = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        hold7    = mk_out(32'h55, 32'h66, 5'd7, 1, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0);
        idle     = '0;

        // Table: inputs and the outputs expected right after the next edge.
        vecs.push_back(mk_vec("word_store",
            mk_in(1, 0, 32'h0000_1004, 32'hDEAD_BEEF, 5'd3, 0, 0, 1, 0, 0, 2'b10, 0),
            mk_out(32'h0000_1004, 32'hDEAD_BEEF, 5'd3, 0, 0, 1, 0, 0, 2'b10, 0, 1, 0, 0)));
        vecs.push_back(mk_vec("word_read_misaligned",
            mk_in(1, 0, 32'h0000_1002, 32'h11, 5'd5, 1, 1, 0, 1, 0, 2'b10, 0),
            mk_out(32'h0000_1002, 32'h11, 5'd5, 0, 0, 0, 1, 0, 2'b10, 0, 1, 1, 0)));
        vecs.push_back(mk_vec("half_read_odd",
            mk_in(1, 0, 32'h0000_2001, 32'h0, 5'd6, 1, 1, 0, 1, 1, 2'b01, 0),
            mk_out(32'h0000_2001, 32'h0, 5'd6, 0, 0, 0, 1, 1, 2'b01, 0, 1, 1, 0)));
        vecs.push_back(mk_vec("half_write_even",
            mk_in(1, 0, 32'h0000_2002, 32'hBEEF, 5'd0, 0, 0, 1, 0, 0, 2'b01, 0),
            mk_out(32'h0000_2002, 32'hBEEF, 5'd0, 0, 0, 1, 0, 0, 2'b01, 0, 1, 0, 0)));
        vecs.push_back(mk_vec("byte_read_odd",
            mk_in(1, 0, 32'h0000_3003, 32'h0, 5'd8, 1, 1, 0, 1, 1, 2'b00, 0),
            mk_out(32'h0000_3003, 32'h0, 5'd8, 1, 1, 0, 1, 1, 2'b00, 0, 1, 0, 0)));
        vecs.push_back(mk_vec("rsvd_width_no_mem",
            mk_in(1, 0, 32'h0000_4001, 32'h0, 5'd9, 1, 0, 0, 0, 0, 2'b11, 0),
            mk_out(32'h0000_4001, 32'h0, 5'd9, 1, 0, 0, 0, 0, 2'b11, 0, 1, 0, 0)));
        vecs.push_back(mk_vec("rsvd_width_store",
            mk_in(1, 0, 32'h0000_4000, 32'h77, 5'd0, 0, 0, 1, 0, 0, 2'b11, 0),
            mk_out(32'h0000_4000, 32'h77, 5'd0, 0, 0, 0, 0, 0, 2'b11, 0, 1, 1, 0)));
        vecs.push_back(mk_vec("load_rd7",
            mk_in(1, 0, 32'h55, 32'h66, 5'd7, 1, 0, 0, 0, 0, 2'b10, 0), hold7));
        vecs.push_back(mk_vec("stall_1",
            mk_in(0, 0, 32'hAAAA, 32'h1, 5'd1, 0, 0, 1, 1, 1, 2'b01, 1), hold7));
        vecs.push_back(mk_vec("stall_2",
            mk_in(0, 0, 32'hBBBB, 32'h2, 5'd2, 1, 1, 0, 0, 0, 2'b00, 0), hold7));
        vecs.push_back(mk_vec("stall_3",
            mk_in(0, 0, 32'hCCC0, 32'h3, 5'd3, 0, 1, 1, 1, 0, 2'b10, 1), hold7));
        vecs.push_back(mk_vec("flush_while_stalled",
            mk_in(0, 1, 32'h100, 32'h5, 5'd4, 1, 0, 1, 0, 0, 2'b10, 0), bubble));
        vecs.push_back(mk_vec("flush_discards_halt",
            mk_in(1, 1, 32'h200, 32'h6, 5'd5, 1, 0, 0, 0, 0, 2'b10, 1), bubble));
        vecs.push_back(mk_vec("load_after_flush",
            mk_in(1, 0, 32'h10, 32'h0, 5'd2, 1, 0, 0, 0, 0, 2'b10, 0),
            mk_out(32'h10, 32'h0, 5'd2, 1, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0)));
        vecs.push_back(mk_vec("halt_load",
            mk_in(1, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 2'b10, 1),
            mk_out(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 0, 1)));
        vecs.push_back(mk_vec("halted_load_drains",
            mk_in(1, 0, 32'h20, 32'h9, 5'd4, 1, 0, 0, 0, 0, 2'b10, 0), bubble_h));
        vecs.push_back(mk_vec("halted_stall_drains",
            mk_in(0, 0, 32'h30, 32'h9, 5'd4, 1, 0, 1, 0, 0, 2'b10, 0), bubble_h));
        vecs.push_back(mk_vec("halted_flush_sticky",
            mk_in(1, 1, 32'h40, 32'h9, 5'd4, 1, 0, 0, 0, 0, 2'b10, 0), bubble_h));

        // Reset across a few edges, released between edges.
        drive(idle);
        i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_state", act, bubble);
        #3;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        check("idle_after_reset", act, bubble);

        foreach (vecs[i]) step(vecs[i].name, vecs[i].stim, vecs[i].exp);

        // Reset leaves HALTED; everything clears immediately without an edge.
        #2;
        i_reset = 1'b0;
        #1;
        check("reset_clears_halted", act, bubble);
        @(negedge i_clk);
        i_reset = 1'b1;
        step("run_after_halt_reset",
             mk_in(1, 0, 32'h88, 32'h99, 5'd11, 1, 0, 0, 0, 0, 2'b10, 0),
             mk_out(32'h88, 32'h99, 5'd11, 1, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0));

        // Asynchronous reset between edges while a valid instruction is held.
        #3;
        i_reset = 1'b0;
        #1;
        check("async_reset_mid_cycle", act, bubble);

        // Release during a stall: bubble persists until the first enabled edge.
        drive(mk_in(0, 0, 32'h1234, 32'h5678, 5'd12, 1, 0, 0, 0, 0, 2'b10, 0));
        @(negedge i_clk);
        i_reset = 1'b1;
        step("stall_after_reset",
             mk_in(0, 0, 32'h1234, 32'h5678, 5'd12, 1, 0, 0, 0, 0, 2'b10, 0), bubble);
        step("first_load_after_reset",
             mk_in(1, 0, 32'h1234, 32'h5678, 5'd12, 1, 0, 0, 0, 0, 2'b10, 0),
             mk_out(32'h1234, 32'h5678, 5'd12, 1, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
